// File: rtl/hazard_sb_if.sv
// Decode-stage hazard inputs and per-stage stall/flush strobes exchanged
// between the datapath (master) and the hazard_sb scoreboard (slave).
interface hazard_sb_if #(
    parameter int RAW   = 5,
    parameter int LAT_W = 3
);
    logic             validD;
    logic [RAW-1:0]   rsD;
    logic [RAW-1:0]   rtD;
    logic             usersD;
    logic             usertD;
    logic             branchD;
    logic [RAW-1:0]   writeregD;
    logic             regwriteD;
    logic             memtoregD;
    logic [LAT_W-1:0] resultlatD;
    logic             divD;
    logic [31:0]      excepttypeM;
    logic             instrStall;
    logic             dataStall;

    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             stallW;
    logic             flushF;
    logic             flushD;
    logic             flushE;
    logic             flushM;
    logic             flushW;
    logic             div_busy;
    logic             axi_stall;

    modport master (
        output validD, rsD, rtD, usersD, usertD, branchD, writeregD, regwriteD,
               memtoregD, resultlatD, divD, excepttypeM, instrStall, dataStall,
        input  stallF, stallD, stallE, stallM, stallW,
               flushF, flushD, flushE, flushM, flushW, div_busy, axi_stall
    );

    modport slave (
        input  validD, rsD, rtD, usersD, usertD, branchD, writeregD, regwriteD,
               memtoregD, resultlatD, divD, excepttypeM, instrStall, dataStall,
        output stallF, stallD, stallE, stallM, stallW,
               flushF, flushD, flushE, flushM, flushW, div_busy, axi_stall
    );
endinterface

// File: rtl/hazard_sb.sv
// Scoreboard hazard unit for the 5-stage MIPS core: per-register result countdown,
// E/M writer trackers for decode-stage branches, and a multi-cycle divider occupancy counter.
module hazard_sb #(
    parameter int NREG    = 32,
    parameter int RAW     = 5,
    parameter int LAT_W   = 3,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst,
    hazard_sb_if.slave bus
);
    localparam int             DCW      = 8;
    localparam logic [DCW-1:0] DIV_LOAD = DCW'(DIV_LAT - 1);

    typedef struct packed {
        logic [RAW-1:0] writereg;
        logic           regwrite;
        logic           memtoreg;
    } stage_t;

    logic [LAT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  pending;
    stage_t           stg_e;
    stage_t           stg_m;
    logic [DCW-1:0]   div_cnt;

    logic flush;
    logic div_busy;
    logic stall_e;
    logic adv;
    logic hz_rs;
    logic hz_rt;
    logic hz;
    logic stall_fd;
    logic issue;
    logic sb_write;

    function automatic logic reg_pending(input logic [NREG-1:0] vec,
                                         input logic [RAW-1:0]  s);
        logic hit;
        hit = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (s == RAW'(r)) hit = vec[r];
        end
        return hit;
    endfunction

    // Branches resolve in D, so they also wait for a result still in E, or a load still in M.
    function automatic logic src_hazard(input logic [RAW-1:0]  s,
                                        input logic            used,
                                        input logic            branch,
                                        input logic [NREG-1:0] vec,
                                        input stage_t          e,
                                        input stage_t          m);
        logic e_hit;
        logic m_hit;
        e_hit = e.regwrite && (e.writereg == s);
        m_hit = m.regwrite && m.memtoreg && (m.writereg == s);
        return used && (s != '0) && (reg_pending(vec, s) || (branch && (e_hit || m_hit)));
    endfunction

    always_comb begin
        // NOTE: default first so every bit has a value on every path and no latch is inferred.
        pending = '0;
        for (int r = 1; r < NREG; r++) begin
            pending[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        flush    = (bus.excepttypeM != '0);
        div_busy = (div_cnt != '0);
        stall_e  = div_busy | bus.dataStall;
        adv      = ~stall_e;
        hz_rs    = src_hazard(bus.rsD, bus.usersD, bus.branchD, pending, stg_e, stg_m);
        hz_rt    = src_hazard(bus.rtD, bus.usertD, bus.branchD, pending, stg_e, stg_m);
        hz       = hz_rs | hz_rt | (bus.divD & div_busy);
        stall_fd = hz | stall_e | bus.instrStall;
        issue    = bus.validD & ~stall_fd & ~flush;
        sb_write = issue & bus.regwriteD & (bus.writeregD != '0);
    end

    assign bus.stallF    = stall_fd;
    assign bus.stallD    = stall_fd;
    assign bus.stallE    = stall_e;
    assign bus.stallM    = bus.dataStall;
    assign bus.stallW    = bus.dataStall;
    assign bus.flushF    = flush;
    assign bus.flushD    = flush;
    assign bus.flushE    = (hz & ~stall_e) | flush;
    assign bus.flushM    = flush;
    assign bus.flushW    = flush;
    assign bus.div_busy  = div_busy;
    assign bus.axi_stall = (div_busy | bus.dataStall | bus.instrStall) & ~flush;

    // Issue implies adv, so a scoreboard write never falls into the frozen branch.
    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is reset entry by entry; a stale count would fake a hazard.
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else if (adv) begin
            for (int r = 1; r < NREG; r++) begin
                if (sb_write && (bus.writeregD == RAW'(r))) begin
                    cnt[r] <= bus.resultlatD;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_e <= '0;
            stg_m <= '0;
        end else if (flush) begin
            stg_e <= '0;
            stg_m <= '0;
        end else if (adv) begin
            stg_e <= issue ? '{writereg: bus.writeregD,
                               regwrite: bus.regwriteD,
                               memtoreg: bus.memtoregD} : '0;
            stg_m <= stg_e;
        end
    end

    // The divider keeps counting through memory stalls; only an exception cancels it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (flush) begin
            div_cnt <= '0;
        end else if (issue && bus.divD) begin
            div_cnt <= DIV_LOAD;
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - DCW'(1);
        end
    end

    a_flush_clears: assert property (@(posedge clk) disable iff (rst)
        flush |=> (div_cnt == '0) && (stg_e == '0) && (stg_m == '0) && (pending == '0));

    a_issue_advances: assert property (@(posedge clk) disable iff (rst)
        issue |-> adv);

    a_div_range: assert property (@(posedge clk) disable iff (rst)
        div_cnt <= DIV_LOAD);

endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb: directed pipeline scenarios plus randomized traffic,
// checked every cycle against a queue/array reference model of the stall rules.
module tb_hazard_sb;
    localparam int NREG    = 32;
    localparam int RAW     = 5;
    localparam int LAT_W   = 3;
    localparam int DIV_LAT = 32;

    typedef struct packed {
        bit        valid;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit        users;
        bit        usert;
        bit        branch;
        bit [4:0]  wr;
        bit        rw;
        bit        mem;
        bit [2:0]  lat;
        bit        div;
        bit [31:0] exc;
        bit        is;
        bit        ds;
        bit        rst;
    } in_t;

    typedef struct packed {
        bit [4:0] stall;
        bit [4:0] flush;
        bit       div_busy;
        bit       axi;
    } out_t;

    typedef struct packed {
        bit [4:0] wr;
        bit       rw;
        bit       mem;
    } slot_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];

    // Reference model: remaining cycles per register, divider cycles left, E/M occupants.
    int    pend[NREG];
    int    div_left;
    slot_t pipe[$];

    hazard_sb_if #(.RAW(RAW), .LAT_W(LAT_W)) bus ();

    hazard_sb #(.NREG(NREG), .RAW(RAW), .LAT_W(LAT_W), .DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < NREG; r++) pend[r] = 0;
        div_left = 0;
        pipe = {};
        pipe.push_back('0);
        pipe.push_back('0);
    endfunction

    function automatic bit reads_hazard(bit [4:0] s, bit used, bit branch);
        if (!used || s == 0) return 1'b0;
        if (pend[s] > 0) return 1'b1;
        if (branch && pipe[0].rw && pipe[0].wr == s) return 1'b1;
        if (branch && pipe[1].rw && pipe[1].mem && pipe[1].wr == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(input in_t i, output out_t o);
        bit fl, busy, se, hz, sd, iss;
        if (i.rst) model_reset();
        fl   = (i.exc != 0);
        busy = (div_left > 0);
        se   = busy || i.ds;
        hz   = reads_hazard(i.rs, i.users, i.branch) || reads_hazard(i.rt, i.usert, i.branch)
               || (i.div && busy);
        sd   = hz || se || i.is;
        iss  = i.valid && !sd && !fl;
        o.stall    = {sd, sd, se, i.ds, i.ds};
        o.flush    = {fl, fl, (hz && !se) || fl, fl, fl};
        o.div_busy = busy;
        o.axi      = (busy || i.ds || i.is) && !fl;
        if (i.rst) return;
        if (fl) begin
            model_reset();
            return;
        end
        if (iss && i.div) div_left = DIV_LAT - 1;
        else if (div_left > 0) div_left--;
        if (!se) begin
            for (int r = 0; r < NREG; r++) if (pend[r] > 0) pend[r]--;
            if (iss && i.rw && i.wr != 0) pend[i.wr] = int'(i.lat);
            pipe.push_front(iss ? slot_t'({i.wr, i.rw, i.mem}) : slot_t'('0));
            void'(pipe.pop_back());
        end
    endfunction

    task automatic apply(input in_t i);
        rst             = i.rst;
        bus.validD      = i.valid;
        bus.rsD         = i.rs;
        bus.rtD         = i.rt;
        bus.usersD      = i.users;
        bus.usertD      = i.usert;
        bus.branchD     = i.branch;
        bus.writeregD   = i.wr;
        bus.regwriteD   = i.rw;
        bus.memtoregD   = i.mem;
        bus.resultlatD  = i.lat;
        bus.divD        = i.div;
        bus.excepttypeM = i.exc;
        bus.instrStall  = i.is;
        bus.dataStall   = i.ds;
    endtask

    task automatic step(input in_t i);
        out_t o;
        @(negedge clk);
        apply(i);
        #1;
        model_step(i, o);
        exp_q.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0);
    endtask

    function automatic in_t op(bit [4:0] rs, bit us, bit [4:0] rt, bit ut, bit br,
                               bit [4:0] wr, bit rw, bit mem, bit [2:0] lat);
        in_t i = '0;
        i.valid = 1'b1;
        i.rs = rs;  i.users = us;
        i.rt = rt;  i.usert = ut;
        i.branch = br;
        i.wr = wr;  i.rw = rw;  i.mem = mem;  i.lat = lat;
        return i;
    endfunction

    function automatic in_t lw(bit [4:0] wr);  return op(0, 0, 0, 0, 0, wr, 1, 1, 3'd1); endfunction
    function automatic in_t alu(bit [4:0] wr); return op(0, 0, 0, 0, 0, wr, 1, 0, 3'd0); endfunction
    function automatic in_t beq(bit [4:0] s);  return op(s, 1, 0, 0, 1, 0, 0, 0, 3'd0); endfunction

    // Holds one instruction in D until it issues and compares its stall-cycle count.
    task automatic hold(input in_t i, input int ds_cycles, input bit [31:0] exc0,
                        input int exp_stalls, input string name);
        int   stalls = 0;
        bit   done   = 1'b0;
        in_t  c;
        for (int k = 0; k < 100 && !done; k++) begin
            c     = i;
            c.ds  = (k < ds_cycles);
            c.exc = (k == 0) ? exc0 : 32'd0;
            step(c);
            #2;
            if (bus.stallD) stalls++;
            if (!bus.stallD && !bus.flushD) done = 1'b1;
        end
        check({name, " issued"}, {31'd0, done}, 32'd1);
        check({name, " stall cycles"}, stalls, exp_stalls);
    endtask

    function automatic in_t rnd();
        in_t i;
        i.valid  = ($urandom_range(0, 9) != 0);
        i.rs     = 5'($urandom_range(0, 7));
        i.rt     = 5'($urandom_range(0, 7));
        i.users  = ($urandom_range(0, 3) != 0);
        i.usert  = ($urandom_range(0, 1) != 0);
        i.branch = ($urandom_range(0, 3) == 0);
        i.wr     = 5'($urandom_range(0, 7));
        i.rw     = ($urandom_range(0, 3) != 0);
        i.mem    = ($urandom_range(0, 2) == 0);
        i.lat    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
        i.div    = ($urandom_range(0, 79) == 0);
        i.exc    = ($urandom_range(0, 59) == 0) ? 32'($urandom_range(1, 255)) : 32'd0;
        i.is     = ($urandom_range(0, 9) == 0);
        i.ds     = ($urandom_range(0, 7) == 0);
        i.rst    = ($urandom_range(0, 299) == 0);
        return i;
    endfunction

    always @(negedge clk) begin : monitor
        out_t e;
        #3;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall FDEMW", 32'({bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.stallW}),
                  32'(e.stall));
            check("flush FDEMW", 32'({bus.flushF, bus.flushD, bus.flushE, bus.flushM, bus.flushW}),
                  32'(e.flush));
            check("div_busy", {31'd0, bus.div_busy}, {31'd0, e.div_busy});
            check("axi_stall", {31'd0, bus.axi_stall}, {31'd0, e.axi});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        in_t r;
        in_t c;
        model_reset();
        r = '0;
        r.rst = 1'b1;
        apply(r);

        // Reset with a live instruction in D: everything quiet.
        r.valid = 1'b1;
        r.rs    = 5'd3;
        r.users = 1'b1;
        step(r);
        #2;
        check("reset outputs", 32'({bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.stallW,
                                    bus.flushF, bus.flushD, bus.flushE, bus.flushM, bus.flushW,
                                    bus.div_busy, bus.axi_stall}), 32'd0);
        step(r);
        idle(2);

        hold(lw(5'd5), 0, 0, 0, "lw5");
        hold(op(5'd5, 1, 0, 0, 0, 5'd9, 1, 0, 3'd0), 0, 0, 1, "load_use");
        idle(3);
        hold(lw(5'd5), 0, 0, 0, "lw5b");
        hold(op(5'd0, 1, 0, 0, 0, 5'd9, 1, 0, 3'd0), 0, 0, 0, "read_r0");
        idle(3);
        hold(alu(5'd4), 0, 0, 0, "addi4");
        hold(beq(5'd4), 0, 0, 1, "alu_branch");
        idle(3);
        hold(alu(5'd4), 0, 0, 0, "addi4b");
        hold(op(5'd4, 1, 0, 0, 0, 5'd9, 1, 0, 3'd0), 0, 0, 0, "alu_alu");
        idle(3);
        hold(lw(5'd4), 0, 0, 0, "lw4");
        hold(beq(5'd4), 0, 0, 2, "load_branch");
        idle(3);
        hold(lw(5'd4), 0, 0, 0, "lw4b");
        hold(op(5'd0, 0, 5'd4, 0, 0, 5'd9, 1, 0, 3'd0), 0, 0, 0, "rt_unused");
        idle(3);

        c = op(0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
        c.div = 1'b1;
        hold(c, 0, 0, 0, "div1");
        hold(c, 0, 0, DIV_LAT - 1, "div_div");
        idle(DIV_LAT + 2);

        hold(lw(5'd7), 0, 0, 0, "lw7");
        hold(op(5'd7, 1, 0, 0, 0, 5'd9, 1, 0, 3'd0), 5, 0, 6, "datastall");
        idle(3);
        hold(lw(5'd5), 0, 0, 0, "lw5c");
        hold(op(5'd5, 1, 0, 0, 0, 5'd9, 1, 0, 3'd0), 0, 32'h4, 1, "exception");
        idle(3);

        // Reset arriving while a load-use stall is pending.
        step(lw(5'd5));
        c = op(5'd5, 1, 0, 0, 0, 5'd9, 1, 0, 3'd0);
        c.rst = 1'b1;
        step(c);
        c.rst = 1'b0;
        hold(c, 0, 0, 0, "reset_midop");
        idle(3);

        for (int k = 0; k < 3000; k++) step(rnd());
        idle(3);

        @(negedge clk);
        #5;
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_sb.md
# hazard_sb

Scoreboard-based hazard and pipeline-control unit for the 5-stage MIPS core. It generalises the combinational stall/flush logic to a parametrised register file size and per-instruction result latency. A per-register countdown scoreboard decides decode-stage stalls, and a multi-cycle divider busy counter is tracked internally. It sits beside the datapath and drives all stall/flush strobes for F/D/E/M/W; forwarding muxes stay in the datapath.

## Interface
Parameters:
- NREG, 32, architectural registers; register 0 never pending
- RAW, 5, register address width (clog2 NREG)
- LAT_W, 3, scoreboard counter width; max result latency 2^LAT_W-1
- DIV_LAT, 32, divider occupancy in cycles (≥2, < 2^8)

Ports (clock and reset first):
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- validD  in  1  D holds a real instruction
- rsD, rtD  in  RAW  source registers in D
- usersD, usertD  in  1  source actually read
- branchD  in  1  D compares operands in decode (branch/jr)
- writeregD  in  RAW  destination of D
- regwriteD  in  1  D writes a register
- memtoregD  in  1  D is a load or mfc0
- resultlatD  in  LAT_W  advances after issue until result is forwardable to E (ALU 0, load/mfc0 1)
- divD  in  1  D is div/divu
- excepttypeM  in  32  nonzero = exception committed in M
- instrStall, dataStall  in  1  memory-side stalls
- stallF, stallD, stallE, stallM, stallW  out  1
- flushF, flushD, flushE, flushM, flushW  out  1
- div_busy  out  1  divider occupied
- axi_stall  out  1  (div_busy|dataStall|instrStall) & ~flush

## Operation
- Internal signals:
  - flush = (excepttypeM != 0).
  - adv = ~stallE.
  - issue = validD & ~stallD & ~flush.
- Scoreboard: cnt[r] (LAT_W bits) per register.
  - On issue with regwriteD and writeregD≠0: cnt[writeregD] ← resultlatD.
  - Otherwise, nonzero counters decrement when adv.
  - If a write and a decrement hit the same register in the same cycle, the write wins.
  - cnt[0] is constant 0.
- Stage trackers regE/memE and regM/memM hold {writereg, regwrite, memtoreg}:
  - On adv: E ← D-values if issue, else cleared (bubble); M ← E.
  - While stallE, both hold.
- Hazard stall per used source s:
  - Normal consumer: cnt[s] ≠ 0.
  - branchD consumer additionally stalls if s matches E writer (regwrite), or M writer with memtoreg.
  - hz = OR over used sources.
- Divider:
  - issue & divD loads div_cnt ← DIV_LAT-1.
  - div_cnt decrements every cycle while nonzero.
  - div_busy = (div_cnt ≠ 0).
  - divD in D while div_busy counts as a hazard.
- Outputs (combinational):
  - stallE = div_busy | dataStall.
  - stallM = stallW = dataStall.
  - stallF = stallD = hz | stallE | instrStall.
  - flushE = (hz & ~stallE) | flush.
  - flushF = flushD = flushM = flushW = flush.
- Exception: flush clears all cnt, trackers and div_cnt on the next edge. The instruction in D is not issued in that cycle.

## Timing
- Reset (async) clears:
  - all cnt, trackers and div_cnt.
  - With rst high and inputs idle, every output is 0.
- Latency:
  - Scoreboard update is visible to D one cycle after issue.
  - Stall outputs are same-cycle combinational from inputs and state.
- Load-use: a consumer directly behind a load (lat 1) gets exactly one bubble. Branch behind a load gets two.
- ALU to branch: one bubble (E match). ALU to normal consumer: zero.
- Divider holds E for DIV_LAT-1 cycles after issue. F/D are held too.
- dataStall freezes counters and trackers: adv is low. div_cnt still counts.
- flush together with hz: flush takes priority and no stall persists next cycle.
- rst asserted mid-operation: state clears immediately, no pending stall survives.

## Test plan
- Reset: assert rst with validD=1, rsD=3 → all outputs 0; after release, cnt all 0.
- Load-use: issue lw $5 (lat 1), next D add rs=$5 → stallD=1 and flushE=1 for exactly 1 cycle, then issue. Same with rs=$0 → no stall.
- Branch:
  - addi $4 then beq rs=$4 → 1 stall cycle.
  - lw $4 then beq rs=$4 → 2 stall cycles.
  - lw $4 then add rt=$4 with usertD=0 → 0 cycles.
- Divider: div with DIV_LAT=32 → stallE=1 and div_busy=1 for 31 cycles; a second div in D stalls until div_busy falls. axi_stall follows.
- dataStall: after lw $7, hold dataStall 5 cycles → cnt[7] stays 1; consumer stalls until 1 cycle after dataStall drops.
- Exception: excepttypeM=0x4 during a pending load-use stall → all flush outputs 1 for that cycle and axi_stall=0. Next cycle hz=0 and cnt cleared.
